// File: rtl/blkdiag_tri_sweep.sv
// ============================================================================
// blkdiag_tri_sweep
//
// Strictly-lower-triangular N x N bit-matrix register with block-diagonal
// update rules. Element (a,b), b<a, takes in_vec[a] when a and b fall into the
// same M-row block, otherwise ~in_vec[a+1]. Diagonal and upper bits are 0.
//
// Update modes (mode is sampled on a beat accepted in IDLE):
//   BULK  (mode=0): one beat writes rows 1..N-1, then DONE.
//   SWEEP (mode=1): one row per accepted beat, rows 1..N-1, then DONE.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_vec    [N:0] data beat; bit a+1 feeds row a's off-block elements
//   in_valid  beat valid
//   in_ready  beat accepted when in_valid & in_ready at a rising edge
//   mode      0 = BULK, 1 = SWEEP
//   abort     cancels an in-progress SWEEP; masks in_ready in every state
//   busy      high while in SWEEP
//   done      one-cycle pulse in DONE
//   row_idx   next row SWEEP will write; 0 outside SWEEP
//   out       [N*N-1:0] matrix, out[a*N+b] = element (a,b)
//
// Optional feature macro: BLKDIAG_TRI_SWEEP_PARITY_EN
//   When defined, adds out_par[N-1:0] with out_par[a] = XOR of row a of out,
//   registered on the same edge as the row itself.
// ============================================================================
module blkdiag_tri_sweep #(
    parameter int N = 16,
    parameter int M = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N:0]            in_vec,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [$clog2(N)-1:0]  row_idx,
    output logic [N*N-1:0]        out
`ifdef BLKDIAG_TRI_SWEEP_PARITY_EN
    ,
    output logic [N-1:0]          out_par
`endif
);

    localparam int RW = $clog2(N);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_r;
    logic [RW-1:0]   row_idx_r;
    logic            busy_r;
    logic            done_r;
    logic [N*N-1:0]  mat_r;
    logic [N*N-1:0]  mat_nxt_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            bulk_wr_s;
    logic            row_wr_s;
    logic [RW-1:0]   wr_idx_s;

    // New contents of row a for beat v: same-block bits copy v[a],
    // off-block bits take ~v[a+1]; bits at and above the diagonal stay 0.
    function automatic logic [N-1:0] row_val(input int a, input logic [N:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int b = 0; b < N; b++) begin
            if (b < a) begin
                if ((a / M) == (b / M)) begin
                    r[b] = v[a];
                end else begin
                    r[b] = ~v[a + 1];
                end
            end else begin
                r[b] = 1'b0;
            end
        end
        return r;
    endfunction

    // Even parity (XOR) of one row.
    function automatic logic row_par(input logic [N-1:0] r);
        return ^r;
    endfunction

    // Handshake: abort masks ready in every state; DONE never accepts.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  in_ready_s = ~abort;
            ST_SWEEP: in_ready_s = ~abort;
            ST_DONE:  in_ready_s = 1'b0;
            default:  in_ready_s = 1'b0;
        endcase
    end

    assign accept_s = in_valid & in_ready_s;

    // Decode which rows an accepted beat writes this cycle.
    always_comb begin
        bulk_wr_s = 1'b0;
        row_wr_s  = 1'b0;
        wr_idx_s  = '0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (mode) begin
                        row_wr_s = 1'b1;
                        wr_idx_s = RW'(1);
                    end else begin
                        bulk_wr_s = 1'b1;
                    end
                end else begin
                    bulk_wr_s = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (accept_s) begin
                    row_wr_s = 1'b1;
                    wr_idx_s = row_idx_r;
                end else begin
                    row_wr_s = 1'b0;
                end
            end
            default: begin
                row_wr_s = 1'b0;
            end
        endcase
    end

    // Next matrix value; row 0 has no elements below the diagonal.
    always_comb begin
        mat_nxt_s = mat_r;
        for (int a = 1; a < N; a++) begin
            if (bulk_wr_s || (row_wr_s && (wr_idx_s == a[RW-1:0]))) begin
                mat_nxt_s[a*N +: N] = row_val(a, in_vec);
            end else begin
                mat_nxt_s[a*N +: N] = mat_r[a*N +: N];
            end
        end
    end

    // Matrix storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mat_r <= '0;
        end else begin
            mat_r <= mat_nxt_s;
        end
    end

`ifdef BLKDIAG_TRI_SWEEP_PARITY_EN
    logic [N-1:0] par_r;

    // Row parity, computed from the next matrix so it tracks out exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_r <= '0;
        end else begin
            for (int a = 0; a < N; a++) begin
                par_r[a] <= row_par(mat_nxt_s[a*N +: N]);
            end
        end
    end

    assign out_par = par_r;
`endif

    // Control FSM with registered busy/done/row_idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            row_idx_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (mode && (N > 2)) begin
                            state_r   <= ST_SWEEP;
                            busy_r    <= 1'b1;
                            row_idx_r <= RW'(2);
                        end else begin
                            // BULK, or a SWEEP whose only row is row 1
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SWEEP: begin
                    if (abort) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        row_idx_r <= '0;
                    end else if (accept_s) begin
                        if (row_idx_r == LAST_ROW) begin
                            state_r   <= ST_DONE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            row_idx_r <= '0;
                        end else begin
                            row_idx_r <= row_idx_r + RW'(1);
                        end
                    end else begin
                        row_idx_r <= row_idx_r;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    row_idx_r <= '0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign busy     = busy_r;
    assign done     = done_r;
    assign row_idx  = row_idx_r;
    assign out      = mat_r;

endmodule

// File: tb/tb_blkdiag_tri_sweep.sv
// ============================================================================
// tb_blkdiag_tri_sweep
//
// Directed bench for blkdiag_tri_sweep at N=16, M=5. Expected row values are
// hand-computed tables for the all-zero and all-one beats.
// ============================================================================
module tb_blkdiag_tri_sweep;

    localparam int N = 16;
    localparam int M = 5;

    // Row a under in_vec = 17'h00000: off-block bits are 1.
    localparam logic [15:0] ZERO_TAB [16] = '{
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h001F, 16'h001F, 16'h001F, 16'h001F, 16'h001F,
        16'h03FF, 16'h03FF, 16'h03FF, 16'h03FF, 16'h03FF,
        16'h7FFF
    };
    // Row a under in_vec = 17'h1FFFF: same-block bits are 1.
    localparam logic [15:0] ONES_TAB [16] = '{
        16'h0000, 16'h0001, 16'h0003, 16'h0007, 16'h000F,
        16'h0000, 16'h0020, 16'h0060, 16'h00E0, 16'h01E0,
        16'h0000, 16'h0400, 16'h0C00, 16'h1C00, 16'h3C00,
        16'h0000
    };

    logic           clk = 1'b0;
    logic           rst;
    logic [N:0]     in_vec;
    logic           in_valid;
    logic           in_ready;
    logic           mode;
    logic           abort;
    logic           busy;
    logic           done;
    logic [3:0]     row_idx;
    logic [N*N-1:0] out;
`ifdef BLKDIAG_TRI_SWEEP_PARITY_EN
    logic [N-1:0]   out_par;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    blkdiag_tri_sweep #(.N(N), .M(M)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vec   (in_vec),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .row_idx  (row_idx),
        .out      (out)
`ifdef BLKDIAG_TRI_SWEEP_PARITY_EN
        ,
        .out_par  (out_par)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Compare rows lo..hi against the zero or ones table.
    task automatic check_rows(input string tag, input int lo, input int hi, input bit ones);
        for (int a = lo; a <= hi; a++) begin
            check_eq($sformatf("%s row%0d", tag, a), 32'(out[a*N +: N]),
                     ones ? 32'(ONES_TAB[a]) : 32'(ZERO_TAB[a]));
        end
    endtask

    // One beat presented at the negedge, sampled 1 time unit after the posedge.
    task automatic beat(input logic [N:0] v, input logic m);
        @(negedge clk);
        in_vec   = v;
        mode     = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        in_vec   = '0;
        in_valid = 1'b0;
        mode     = 1'b0;
        abort    = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst out_nz", 32'(|out), 32'd0);
        check_eq("rst row_idx", 32'(row_idx), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("idle in_ready", 32'(in_ready), 32'd1);

        // BULK zeros
        beat(17'h00000, 1'b0);
        check_rows("bulk0", 0, 15, 1'b0);
        check_eq("bulk0 done", 32'(done), 32'd1);
        check_eq("bulk0 in_ready", 32'(in_ready), 32'd0);
        tick();
        check_eq("bulk0 done_after", 32'(done), 32'd0);

        // BULK ones
        beat(17'h1FFFF, 1'b0);
        check_rows("bulk1", 0, 15, 1'b1);
        check_eq("bulk1 done", 32'(done), 32'd1);
        check_eq("bulk1 busy", 32'(busy), 32'd0);
`ifdef BLKDIAG_TRI_SWEEP_PARITY_EN
        check_eq("par6", 32'(out_par[6]), 32'd1);
        check_eq("par4", 32'(out_par[4]), 32'd0);
        check_eq("par5", 32'(out_par[5]), 32'd0);
`endif
        tick();
        check_eq("bulk1 done_after", 32'(done), 32'd0);
        check_eq("bulk1 in_ready_after", 32'(in_ready), 32'd1);

        // SWEEP zeros over the ones pattern, 2-cycle gap after 7th beat
        beat(17'h00000, 1'b1);
        check_eq("sw row_idx1", 32'(row_idx), 32'd2);
        check_eq("sw busy1", 32'(busy), 32'd1);
        check_eq("sw row1", 32'(out[1*N +: N]), 32'(ZERO_TAB[1]));
        check_eq("sw row2_old", 32'(out[2*N +: N]), 32'(ONES_TAB[2]));
        for (int k = 2; k <= 15; k++) begin
            if (k == 8) begin
                check_eq("sw row7", 32'(out[7*N +: N]), 32'(ZERO_TAB[7]));
                check_eq("sw row8_old", 32'(out[8*N +: N]), 32'(ONES_TAB[8]));
                for (int g = 0; g < 2; g++) begin
                    tick();
                    check_eq("gap row_idx", 32'(row_idx), 32'd8);
                    check_eq("gap busy", 32'(busy), 32'd1);
                    check_eq("gap done", 32'(done), 32'd0);
                end
                check_eq("gap row8_old", 32'(out[8*N +: N]), 32'(ONES_TAB[8]));
            end
            // mode is ignored outside IDLE
            beat(17'h00000, 1'b0);
            if (k < 15) begin
                check_eq($sformatf("sw row_idx%0d", k), 32'(row_idx), 32'(k + 1));
                check_eq($sformatf("sw busy%0d", k), 32'(busy), 32'd1);
                check_eq($sformatf("sw done%0d", k), 32'(done), 32'd0);
            end else begin
                check_eq("sw done_end", 32'(done), 32'd1);
                check_eq("sw busy_end", 32'(busy), 32'd0);
                check_eq("sw row_idx_end", 32'(row_idx), 32'd0);
            end
        end
        check_rows("sweep", 0, 15, 1'b0);
        tick();
        check_eq("sw done_after", 32'(done), 32'd0);

        // Abort: ones fill, 4 zero SWEEP beats, then abort with a valid beat
        beat(17'h1FFFF, 1'b0);
        tick();
        beat(17'h00000, 1'b1);
        for (int k = 0; k < 3; k++) beat(17'h00000, 1'b0);
        check_eq("ab row_idx", 32'(row_idx), 32'd5);
        @(negedge clk);
        in_vec   = 17'h00000;
        in_valid = 1'b1;
        abort    = 1'b1;
        #1;
        check_eq("ab in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check_eq("ab busy", 32'(busy), 32'd0);
        check_eq("ab row_idx0", 32'(row_idx), 32'd0);
        check_eq("ab done", 32'(done), 32'd0);
        check_rows("ab", 1, 4, 1'b0);
        check_rows("ab", 5, 15, 1'b1);
        #1;
        check_eq("ab idle in_ready", 32'(in_ready), 32'd1);
        tick();
        check_eq("ab done_next", 32'(done), 32'd0);

        // Abort in IDLE only masks ready
        @(negedge clk);
        in_vec   = 17'h00000;
        mode     = 1'b0;
        in_valid = 1'b1;
        abort    = 1'b1;
        #1;
        check_eq("idle_ab in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check_eq("idle_ab done", 32'(done), 32'd0);
        check_eq("idle_ab row5", 32'(out[5*N +: N]), 32'(ONES_TAB[5]));

        // Asynchronous reset mid-SWEEP at row_idx 9
        beat(17'h00000, 1'b1);
        for (int k = 0; k < 7; k++) beat(17'h00000, 1'b0);
        check_eq("ar row_idx9", 32'(row_idx), 32'd9);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar out_nz", 32'(|out), 32'd0);
        check_eq("ar row_idx", 32'(row_idx), 32'd0);
        check_eq("ar busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        beat(17'h1FFFF, 1'b0);
        check_rows("post_rst", 0, 15, 1'b1);
        check_eq("post_rst done", 32'(done), 32'd1);
        tick();
        check_eq("post_rst done_after", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
